// File: rtl/sobel_stream_filter_if.sv
// rtl/sobel_stream_filter_if.sv - pixel input/output handshake bundle for sobel_stream_filter
//
// Signals:
//   in_valid / in_ready / pixel_in    : input pixel stream (source -> filter)
//   out_valid / out_ready / pixel_out : gradient output stream (filter -> sink)
// Modports:
//   slave  : the filter's view
//   master : the source/sink (bench or surrounding fabric) view
interface sobel_stream_filter_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] pixel_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] pixel_out;

    modport slave (
        input  in_valid, pixel_in, out_ready,
        output in_ready, out_valid, pixel_out
    );

    modport master (
        output in_valid, pixel_in, out_ready,
        input  in_ready, out_valid, pixel_out
    );
endinterface

// File: rtl/sobel_stream_filter.sv
// rtl/sobel_stream_filter.sv - streaming 3x3 Sobel edge detector with runtime frame size
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : frame start, sampled in IDLE only
//   img_width/img_height  : frame columns/rows, latched on start
//   mode                  : 0=|Gx|+|Gy| 1=|Gx| 2=|Gy| 3=max, latched on start
//   thresh                : binarisation threshold (only with SOBEL_THRESH_EN)
//   busy                  : high outside IDLE
//   done                  : one-cycle end-of-frame pulse
//   cfg_err               : illegal dimensions on the last accepted start
//   s                     : pixel in/out streams (sobel_stream_filter_if.slave)
// Optional feature macro: SOBEL_THRESH_EN
module sobel_stream_filter #(
    parameter int WIDTH     = 8,
    parameter int MAX_WIDTH = 1024,
    parameter int DW        = $clog2(MAX_WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DW-1:0]        img_width,
    input  logic [DW-1:0]        img_height,
    input  logic [1:0]           mode,
`ifdef SOBEL_THRESH_EN
    input  logic [WIDTH-1:0]     thresh,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err,
    sobel_stream_filter_if.slave s
);
    localparam int AW = $clog2(MAX_WIDTH);
    localparam int SW = WIDTH + 3;
    localparam logic [SW:0] MAXV = (SW+1)'((1 << WIDTH) - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, FIN} state_t;
    state_t state;

    logic [DW-1:0]    w_reg, h_reg, col, row;
    logic [1:0]       mode_reg;
    logic [WIDTH-1:0] lb0 [MAX_WIDTH];   // row r-1
    logic [WIDTH-1:0] lb1 [MAX_WIDTH];   // row r-2
    logic [WIDTH-1:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
    logic [WIDTH-1:0] n00, n01, n02, n10, n11, n12, n20, n21, n22;

    logic accept, produce, last_px, dims_ok;
    logic signed [SW-1:0] gx, gy;
    logic [SW-1:0] ax, ay;
    logic [SW:0]   mag;
    logic [WIDTH-1:0] sat, res;

    assign s.in_ready = (state == RUN) && (!s.out_valid || s.out_ready);
    assign accept     = s.in_valid && s.in_ready;
    assign produce    = (row >= DW'(2)) && (col >= DW'(2));
    assign last_px    = (row == h_reg - DW'(1)) && (col == w_reg - DW'(1));
    assign dims_ok    = (img_width >= DW'(3)) && (img_width <= DW'(MAX_WIDTH))
                        && (img_height >= DW'(3));

    function automatic logic signed [SW-1:0] ext(input logic [WIDTH-1:0] v);
        return $signed({3'b000, v});
    endfunction

    // Window as it will look after this acceptance; the two older columns
    // are cleared at a row start so no pixels from the previous row leak in.
    always_comb begin
        n00 = (col == '0) ? '0 : p01;
        n10 = (col == '0) ? '0 : p11;
        n20 = (col == '0) ? '0 : p21;
        n01 = (col == '0) ? '0 : p02;
        n11 = (col == '0) ? '0 : p12;
        n21 = (col == '0) ? '0 : p22;
        n02 = lb1[col[AW-1:0]];
        n12 = lb0[col[AW-1:0]];
        n22 = s.pixel_in;
    end

    always_comb begin
        gx = (ext(n02) + (ext(n12) <<< 1) + ext(n22))
           - (ext(n00) + (ext(n10) <<< 1) + ext(n20));
        gy = (ext(n20) + (ext(n21) <<< 1) + ext(n22))
           - (ext(n00) + (ext(n01) <<< 1) + ext(n02));
        ax = (gx < 0) ? SW'(-gx) : SW'(gx);
        ay = (gy < 0) ? SW'(-gy) : SW'(gy);
        case (mode_reg)
            2'd0:    mag = {1'b0, ax} + {1'b0, ay};
            2'd1:    mag = {1'b0, ax};
            2'd2:    mag = {1'b0, ay};
            default: mag = (ax > ay) ? {1'b0, ax} : {1'b0, ay};
        endcase
        sat = (mag > MAXV) ? {WIDTH{1'b1}} : mag[WIDTH-1:0];
`ifdef SOBEL_THRESH_EN
        res = (sat > thresh) ? {WIDTH{1'b1}} : '0;
`else
        res = sat;
`endif
    end

    // Line buffers carry no reset: rows 0 and 1 overwrite them before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col[AW-1:0]] <= lb0[col[AW-1:0]];
            lb0[col[AW-1:0]] <= s.pixel_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            w_reg       <= '0;
            h_reg       <= '0;
            mode_reg    <= '0;
            col         <= '0;
            row         <= '0;
            {p00, p01, p02, p10, p11, p12, p20, p21, p22} <= '0;
            s.out_valid <= 1'b0;
            s.pixel_out <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            done <= 1'b0;

            if (accept && produce) begin
                s.out_valid <= 1'b1;
                s.pixel_out <= res;
            end else if (s.out_ready) begin
                s.out_valid <= 1'b0;
            end

            if (accept) begin
                {p00, p01, p02} <= {n00, n01, n02};
                {p10, p11, p12} <= {n10, n11, n12};
                {p20, p21, p22} <= {n20, n21, n22};
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        w_reg    <= img_width;
                        h_reg    <= img_height;
                        mode_reg <= mode;
                        col      <= '0;
                        row      <= '0;
                        busy     <= 1'b1;
                        cfg_err  <= !dims_ok;
                        if (dims_ok) begin
                            state <= RUN;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (last_px) begin
                            col   <= '0;
                            row   <= '0;
                            state <= FLUSH;
                        end else if (col == w_reg - DW'(1)) begin
                            col <= '0;
                            row <= row + DW'(1);
                        end else begin
                            col <= col + DW'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (!s.out_valid || s.out_ready) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sobel_stream_filter.sv
// tb/tb_sobel_stream_filter.sv - table-driven self-checking bench for sobel_stream_filter
module tb_sobel_stream_filter;
    localparam int WIDTH     = 8;
    localparam int MAX_WIDTH = 1024;
    localparam int DW        = $clog2(MAX_WIDTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] img_width = '0;
    logic [DW-1:0] img_height = '0;
    logic [1:0]    mode = '0;
    logic          busy, done, cfg_err;
`ifdef SOBEL_THRESH_EN
    logic [WIDTH-1:0] thresh = 8'd150;
`endif

    sobel_stream_filter_if #(.WIDTH(WIDTH)) bus ();

    sobel_stream_filter #(.WIDTH(WIDTH), .MAX_WIDTH(MAX_WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .img_width  (img_width),
        .img_height (img_height),
        .mode       (mode),
`ifdef SOBEL_THRESH_EN
        .thresh     (thresh),
`endif
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .s          (bus)
    );

    always #5 clk = ~clk;

    // pat: 0 uniform 77, 1 col0=0 else 100, 2 cols0-1=0 else 50, 3 random
    // exp_val < 0 means use the golden model instead of a constant
    typedef struct {
        int w; int h; int mode; int pat; bit stall;
        int exp_n; int exp_val; bit exp_err;
    } vec_t;

    vec_t vecs[12];
    int   img [128];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int thr(input int v);
`ifdef SOBEL_THRESH_EN
        return (v > 150) ? 255 : 0;
`else
        return v;
`endif
    endfunction

    function automatic int px(input int w, input int r, input int c);
        return img[r*w + c];
    endfunction

    function automatic int golden(input int w, input int r, input int c, input int m);
        int gx, gy, v;
        gx = px(w,r-1,c+1) + 2*px(w,r,c+1) + px(w,r+1,c+1)
           - px(w,r-1,c-1) - 2*px(w,r,c-1) - px(w,r+1,c-1);
        gy = px(w,r+1,c-1) + 2*px(w,r+1,c) + px(w,r+1,c+1)
           - px(w,r-1,c-1) - 2*px(w,r-1,c) - px(w,r-1,c+1);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        case (m)
            0: v = gx + gy;
            1: v = gx;
            2: v = gy;
            default: v = (gx > gy) ? gx : gy;
        endcase
        if (v > 255) v = 255;
        return thr(v);
    endfunction

    task automatic fill_image(input int w, input int h, input int pat);
        if (w * h > 128) return;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                case (pat)
                    0: img[r*w+c] = 77;
                    1: img[r*w+c] = (c < 1) ? 0 : 100;
                    2: img[r*w+c] = (c < 2) ? 0 : 50;
                    default: img[r*w+c] = $urandom_range(0, 255);
                endcase
    endtask

    task automatic run_frame(input int idx);
        vec_t v;
        int exp_out [128];
        int n_in, n_out, cyc, done_cyc, n_exp_in, k;
        bit done_seen, err_seen, stall_prev;
        logic [WIDTH-1:0] held;
        v = vecs[idx];
        n_in = 0; n_out = 0; cyc = 0; done_cyc = -1;
        done_seen = 0; err_seen = 0; stall_prev = 0; held = '0;
        n_exp_in = v.exp_err ? 0 : v.w * v.h;
        fill_image(v.w, v.h, v.pat);
        k = 0;
        if (!v.exp_err)
            for (int r = 1; r < v.h - 1; r++)
                for (int c = 1; c < v.w - 1; c++) begin
                    exp_out[k] = (v.exp_val >= 0) ? thr(v.exp_val) : golden(v.w, r, c, v.mode);
                    k++;
                end

        @(negedge clk);
        start = 1'b1;
        img_width = DW'(v.w);
        img_height = DW'(v.h);
        mode = 2'(v.mode);
        @(negedge clk);
        start = 1'b0;
        while (!done_seen && cyc < 5000) begin
            if (stall_prev) begin
                check($sformatf("v%0d_hold_valid", idx), int'(bus.out_valid), 1);
                check($sformatf("v%0d_hold_data", idx), int'(bus.pixel_out), int'(held));
            end
            if (done) begin
                done_seen = 1;
                done_cyc = cyc;
                err_seen = cfg_err;
            end
            bus.out_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_valid  = (n_in < v.w * v.h) &&
                            (v.stall ? ($urandom_range(0, 3) != 0) : 1'b1);
            bus.pixel_in  = WIDTH'(img[n_in % 128]);
            #1;
            if (bus.in_valid && bus.in_ready) n_in++;
            if (bus.out_valid && bus.out_ready) begin
                if (n_out < k)
                    check($sformatf("v%0d_out%0d", idx, n_out), int'(bus.pixel_out), exp_out[n_out]);
                else
                    check($sformatf("v%0d_extra_out", idx), n_out, k - 1);
                n_out++;
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            held = bus.pixel_out;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check($sformatf("v%0d_done_seen", idx), int'(done_seen), 1);
        check($sformatf("v%0d_accepted", idx), n_in, n_exp_in);
        check($sformatf("v%0d_out_count", idx), n_out, v.exp_n);
        check($sformatf("v%0d_cfg_err", idx), int'(err_seen), int'(v.exp_err));
        if (v.exp_err)
            check($sformatf("v%0d_done_latency_ok", idx), int'(done_cyc >= 0 && done_cyc <= 1), 1);
    endtask

    initial begin
        int n_fed;
        vecs[0]  = '{5, 5, 0, 0, 1'b0, 9, 0, 1'b0};
        vecs[1]  = '{4, 4, 0, 2, 1'b0, 4, 200, 1'b0};
        vecs[2]  = '{4, 4, 3, 2, 1'b0, 4, 200, 1'b0};
        vecs[3]  = '{3, 3, 0, 1, 1'b0, 1, 255, 1'b0};
        vecs[4]  = '{3, 3, 1, 1, 1'b0, 1, 255, 1'b0};
        vecs[5]  = '{3, 3, 2, 1, 1'b0, 1, 0, 1'b0};
        vecs[6]  = '{16, 8, 0, 3, 1'b1, 84, -1, 1'b0};
        vecs[7]  = '{16, 8, 3, 3, 1'b1, 84, -1, 1'b0};
        vecs[8]  = '{2, 5, 0, 0, 1'b0, 0, 0, 1'b1};
        vecs[9]  = '{MAX_WIDTH + 1, 4, 0, 0, 1'b0, 0, 0, 1'b1};
        vecs[10] = '{5, 2, 0, 0, 1'b0, 0, 0, 1'b1};
        vecs[11] = '{4, 4, 0, 2, 1'b0, 4, 200, 1'b0};

        bus.in_valid = 1'b0;
        bus.pixel_in = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_pixel_out", int'(bus.pixel_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_cfg_err", int'(cfg_err), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_frame(i);

        // Mid-frame reset with an output pending under backpressure.
        fill_image(4, 4, 2);
        @(negedge clk);
        start = 1'b1; img_width = DW'(4); img_height = DW'(4); mode = 2'd0;
        @(negedge clk);
        start = 1'b0;
        bus.out_ready = 1'b0;
        n_fed = 0;
        for (int c = 0; c < 100 && n_fed < 11; c++) begin
            bus.in_valid = 1'b1;
            bus.pixel_in = WIDTH'(img[n_fed]);
            #1;
            if (bus.in_ready) n_fed++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("pre_rst_fed", n_fed, 11);
        check("pre_rst_out_valid", int'(bus.out_valid), 1);
        check("pre_rst_pixel_out", int'(bus.pixel_out), thr(200));
        check("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", int'(bus.in_ready), 0);
        check("mid_rst_out_valid", int'(bus.out_valid), 0);
        check("mid_rst_pixel_out", int'(bus.pixel_out), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_cfg_err", int'(cfg_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        run_frame(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
